// File: rtl/arctic_pkg.sv
// Shared types and constants for the Arctic Circle sequencer.
// No logic; lfsr_next is the one-step Galois update used by the LFSR.
package arctic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_SETTLE,
        S_FRAME,
        S_DONE
    } seq_state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

endpackage

// File: rtl/arctic_if.sv
// Frame handoff between the sequencer and the display/readout consumer.
// gen is only meaningful while frame_valid is high.
interface arctic_if #(
    parameter int ORD_W = 4
);

    logic             frame_valid;
    logic             frame_ready;
    logic [ORD_W-1:0] gen;

    modport master (output frame_valid, output gen, input frame_ready);
    modport slave  (input frame_valid, input gen, output frame_ready);

endinterface

// File: rtl/arctic_lfsr.sv
// 16-bit Galois LFSR supplying per-node random bits; advances every cycle.
// Latency: load/seed visible on q one cycle after it is sampled.
// Backpressure: none; free-running, the zero guard reseeds a stuck-at-zero state.
module arctic_lfsr
    import arctic_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (q == 16'h0000) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/arctic_seq.sv
// Sequencer: clears the node array, then strobes one update per generation and offers each frame.
// Latency: node_clr 1 cycle after start, first node_en 2 cycles after, frame 3+SETTLE after.
// Backpressure: FRAME holds frame_valid/gen until frame_ready; no strobes issue while stalled.
module arctic_seq
    import arctic_pkg::*;
#(
    parameter int          CELLS  = 16,
    parameter int          ORD_W  = 4,
    parameter int          SETTLE = 2,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ORD_W-1:0] order,
    input  logic             abort,
    input  logic             seed_load,
    arctic_if.master         frm,
    output logic             node_clr,
    output logic             node_en,
    output logic [CELLS-1:0] rnd,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [ORD_W-1:0] tgt;
    logic [ORD_W-1:0] gen_q;
    logic [3:0]       cnt;
    logic [15:0]      lfsr_q;
    logic             hs;
    logic             last_gen;

    assign hs = (state == S_FRAME) && frm.frame_ready;
    // Compared one bit wider so gen+1 cannot wrap onto a small target.
    assign last_gen = ({1'b0, gen_q} + {{ORD_W{1'b0}}, 1'b1}) == {1'b0, tgt};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = (tgt == '0) ? S_DONE : S_STEP;
            S_STEP:   state_nxt = (SETTLE == 0) ? S_FRAME : S_SETTLE;
            S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_FRAME;
            S_FRAME:  if (hs) state_nxt = last_gen ? S_DONE : S_STEP;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // Abort wins over everything, including a handshake in the same cycle.
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tgt   <= '0;
            gen_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tgt   <= order;
                        gen_q <= '0;
                        cnt   <= '0;
                    end
                end
                S_STEP:   cnt <= '0;
                S_SETTLE: cnt <= cnt + 4'd1;
                S_FRAME:  if (hs && !last_gen && !abort) gen_q <= gen_q + 1'b1;
                default:  ;
            endcase
        end
    end

    arctic_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_load),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign node_clr        = (state == S_CLEAR);
    assign node_en         = (state == S_STEP);
    assign frm.frame_valid = (state == S_FRAME);
    assign frm.gen         = gen_q;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);
    assign rnd             = lfsr_q[CELLS-1:0];

endmodule

// File: tb/tb_arctic_seq.sv
// Bench for arctic_seq: run table with a frame scoreboard, plus reset, LFSR and seed_load sequences.
module tb_arctic_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] order;
    logic       abort;
    logic       seed_load;
    logic       frame_ready;
    logic       node_clr;
    logic       node_en;
    logic [15:0] rnd;
    logic       busy;
    logic       done;

    int n_pass = 0;
    int n_tot  = 0;
    int sb[$];

    always #5 clk = ~clk;

    arctic_if #(.ORD_W(4)) frm ();
    assign frm.frame_ready = frame_ready;

    arctic_seq #(
        .CELLS  (16),
        .ORD_W  (4),
        .SETTLE (2),
        .SEED   (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .order     (order),
        .abort     (abort),
        .seed_load (seed_load),
        .frm       (frm),
        .node_clr  (node_clr),
        .node_en   (node_en),
        .rnd       (rnd),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int order;
        int stall_gen;
        int stall_len;
        int abort_gen;
        int poke;
        int exp_frames;
        int exp_en;
        int exp_done;
        int exp_done_at;
        int exp_idle_at;
        int exp_first_en;
    } run_t;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tot++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    endtask

    task automatic run_one(input int idx, input run_t r);
        int n_clr = 0, n_en = 0, n_done = 0;
        int done_at = -1, idle_at = -1, first_en = -1, last_en = -1, bad_gap = 0;
        int stall_left = 0;
        bit stalled = 0;
        @(posedge clk); #1;
        start = 1'b1; order = 4'(r.order); abort = 1'b0; frame_ready = 1'b1;
        for (int g = 0; g < r.exp_frames; g++) sb.push_back(g);
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; frame_ready = 1'b1;
            if (r.poke != 0 && k == 3) begin
                start = 1'b1; order = 4'd0;
            end
            if (node_clr) n_clr++;
            if (node_en) begin
                if (n_en == 0) first_en = k;
                else if (k - last_en != 4) bad_gap++;
                last_en = k;
                n_en++;
            end
            if (done) begin
                n_done++;
                done_at = k;
            end
            if (frm.frame_valid) begin
                if (r.stall_len > 0 && !stalled && int'(frm.gen) == r.stall_gen) begin
                    stalled = 1;
                    stall_left = r.stall_len;
                end
                if (stall_left > 0) begin
                    frame_ready = 1'b0;
                    stall_left--;
                end
                if (int'(frm.gen) == r.abort_gen) abort = 1'b1;
                if (sb.size() == 0) chk($sformatf("run%0d_extra_frame", idx), int'(frm.gen), -1);
                else begin
                    chk($sformatf("run%0d_frame_gen", idx), int'(frm.gen), sb[0]);
                    if (frame_ready) void'(sb.pop_front());
                end
            end
            if (!busy) begin
                idle_at = k;
                break;
            end
        end
        start = 1'b0; abort = 1'b0; frame_ready = 1'b1;
        chk($sformatf("run%0d_clr_count", idx), n_clr, 1);
        chk($sformatf("run%0d_en_count", idx), n_en, r.exp_en);
        chk($sformatf("run%0d_first_en", idx), first_en, r.exp_first_en);
        chk($sformatf("run%0d_done_count", idx), n_done, r.exp_done);
        chk($sformatf("run%0d_done_at", idx), done_at, r.exp_done_at);
        chk($sformatf("run%0d_idle_at", idx), idle_at, r.exp_idle_at);
        chk($sformatf("run%0d_frames_left", idx), sb.size(), 0);
        if (r.stall_len == 0) chk($sformatf("run%0d_en_spacing", idx), bad_gap, 0);
        sb.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run_t runs[7];
        logic [15:0] lfsr_tbl[7];
        int n_done;
        int idle_seen;

        //             ord sg sl ag pk frm en dn dat idl fen
        runs[0] = '{3, -1, 0, -1, 1, 3, 3, 1, 14, 15, 2};
        runs[1] = '{3,  1, 7, -1, 0, 3, 3, 1, 21, 22, 2};
        runs[2] = '{0, -1, 0, -1, 0, 0, 0, 1,  2,  3, -1};
        runs[3] = '{3, -1, 0,  1, 0, 2, 2, 0, -1, 10, 2};
        runs[4] = '{2, -1, 0, -1, 0, 2, 2, 1, 10, 11, 2};
        runs[5] = '{1, -1, 0, -1, 0, 1, 1, 1,  6,  7, 2};
        runs[6] = '{15, -1, 0, -1, 0, 15, 15, 1, 62, 63, 2};

        lfsr_tbl[0] = 16'hACE1; lfsr_tbl[1] = 16'hE270; lfsr_tbl[2] = 16'h7138;
        lfsr_tbl[3] = 16'h389C; lfsr_tbl[4] = 16'h1C4E; lfsr_tbl[5] = 16'h0E27;
        lfsr_tbl[6] = 16'hB313;

        rst_n = 1'b0; start = 1'b0; order = 4'd0; abort = 1'b0;
        seed_load = 1'b0; frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_strobes", int'({node_clr, node_en, frm.frame_valid, done}), 0);
        chk("reset_gen", int'(frm.gen), 0);
        chk("reset_rnd", int'(rnd), int'(lfsr_tbl[0]));
        rst_n = 1'b1;

        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("idle_outputs", int'({busy, node_clr, node_en, frm.frame_valid, done}), 0);
            if (i < 7) chk($sformatf("lfsr_step%0d", i), int'(rnd), int'(lfsr_tbl[i]));
        end

        for (int i = 0; i < 7; i++) run_one(i, runs[i]);

        // Reset while settling generation 1.
        @(posedge clk); #1;
        start = 1'b1; order = 4'd3;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("midrst_pre_gen", int'(frm.gen), 1);
        chk("midrst_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_strobes", int'({node_clr, node_en, frm.frame_valid, done}), 0);
        chk("midrst_gen", int'(frm.gen), 0);
        chk("midrst_rnd", int'(rnd), int'(lfsr_tbl[0]));
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_stays_idle", int'(busy), 0);

        // seed_load in the middle of a run restarts the random sequence only.
        @(posedge clk); #1;
        start = 1'b1; order = 4'd2;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("seedload_rnd0", int'(rnd), int'(lfsr_tbl[0]));
        chk("seedload_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("seedload_rnd1", int'(rnd), int'(lfsr_tbl[1]));
        n_done = 0;
        idle_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) n_done++;
            if (!busy) begin
                idle_seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("seedload_done_count", n_done, 1);
        chk("seedload_idle", idle_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
